// File: rtl/rptr_empty_sync.sv
// rptr_empty_sync: read-side pointer, empty/almost-empty/count status with internal write-pointer synchroniser.
// Optional RPTR_UNDERFLOW_EN adds the sticky runderflow flag.
module rptr_empty_sync #(
  parameter int n           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rrst_n,
  input  logic         rinc,
  input  logic [n:0]   w_gptr,
  input  logic [n:0]   ae_thresh,
  input  logic         clr_underflow,
  output logic [n-1:0] r_bptr,
  output logic [n:0]   r_gptr,
  output logic [n:0]   rcount,
  output logic         rempty,
  output logic         ralmost_empty,
  output logic         runderflow
);
  logic [n:0] rbin_q, rbin_d, r_gptr_q, r_gptr_d, rcount_q, rcount_d, wbin, wq;
  logic [n:0] sync_q [SYNC_STAGES];
  logic       rempty_q, rempty_d, ralmost_q, ralmost_d;
  assign wq = sync_q[SYNC_STAGES-1];
  for (genvar g = 0; g <= n; g++) begin : g_g2b
    assign wbin[g] = ^wq[n:g];
  end
  always_comb begin
    rbin_d    = rbin_q + (n+1)'(rinc & ~rempty_q);
    r_gptr_d  = rbin_d ^ (rbin_d >> 1);
    rcount_d  = wbin - rbin_d;
    rempty_d  = r_gptr_d == wq;
    ralmost_d = rcount_d <= ae_thresh;
  end
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      r_gptr_q  <= '0;
      rcount_q  <= '0;
      rempty_q  <= 1'b1;
      ralmost_q <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      rbin_q    <= rbin_d;
      r_gptr_q  <= r_gptr_d;
      rcount_q  <= rcount_d;
      rempty_q  <= rempty_d;
      ralmost_q <= ralmost_d;
      sync_q[0] <= w_gptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
`ifdef RPTR_UNDERFLOW_EN
  logic uf_q, uf_d;
  assign uf_d = (rinc & rempty_q) | (uf_q & ~clr_underflow);
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) uf_q <= 1'b0;
    else         uf_q <= uf_d;
  end
  assign runderflow = uf_q;
`else
  logic unused_clr;
  assign unused_clr = clr_underflow;
  assign runderflow = 1'b0;
`endif
  assign r_bptr        = rbin_q[n-1:0];
  assign r_gptr        = r_gptr_q;
  assign rcount        = rcount_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = ralmost_q;
endmodule

// File: tb/tb_rptr_empty_sync.sv
// tb_rptr_empty_sync: occupancy model (write/read counts plus sync delay) checked every cycle, plus directed literals.
module tb_rptr_empty_sync;
  localparam int N = 4, S = 2;
`ifdef RPTR_UNDERFLOW_EN
  localparam bit UF = 1'b1;
`else
  localparam bit UF = 1'b0;
`endif
  logic clk = 1'b0, rrst_n = 1'b0, rinc = 1'b0, clr_underflow = 1'b0;
  logic [N:0] w_gptr, ae_thresh, r_gptr, rcount;
  logic [N-1:0] r_bptr;
  logic rempty, ralmost_empty, runderflow;
  int wr = 0, passed = 0, total = 0;
  int rd;
  int p [S];
  logic [N:0] m_cnt, prev_g;
  logic m_empty, m_ae, m_uf;

  function automatic logic [N:0] gray(int v);
    logic [N:0] b;
    b = v[N:0];
    return b ^ (b >> 1);
  endfunction

  assign w_gptr = gray(wr);
  always #5 clk = ~clk;

  rptr_empty_sync #(.n(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rrst_n(rrst_n), .rinc(rinc), .w_gptr(w_gptr), .ae_thresh(ae_thresh),
    .clr_underflow(clr_underflow), .r_bptr(r_bptr), .r_gptr(r_gptr), .rcount(rcount),
    .rempty(rempty), .ralmost_empty(ralmost_empty), .runderflow(runderflow)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: the read side sees the write count sampled S edges ago; occupancy is that minus reads.
  always @(posedge clk or negedge rrst_n) begin : model
    if (!rrst_n) begin
      rd <= 0;
      for (int i = 0; i < S; i++) p[i] <= 0;
      m_cnt <= '0; m_empty <= 1'b1; m_ae <= 1'b1; m_uf <= 1'b0;
    end else begin : step
      automatic int rd_n = rd + ((rinc && !m_empty) ? 1 : 0);
      automatic logic [N:0] c = (N+1)'(p[S-1] - rd_n);
      rd <= rd_n;
      for (int i = S-1; i > 0; i--) p[i] <= p[i-1];
      p[0] <= wr;
      m_cnt <= c;
      m_empty <= (c == 0);
      m_ae <= (c <= ae_thresh);
      m_uf <= UF && ((rinc && m_empty) || (m_uf && !clr_underflow));
    end
  end

  always @(negedge clk) begin
    if (!rrst_n) prev_g <= '0;
    else begin
      chk("m_rempty", rempty, m_empty);
      chk("m_rcount", rcount, m_cnt);
      chk("m_ralmost", ralmost_empty, m_ae);
      chk("m_runderflow", runderflow, m_uf);
      chk("m_r_bptr", r_bptr, rd % 16);
      chk("m_r_gptr", r_gptr, gray(rd));
      if (r_gptr != prev_g) chk("gray_step", $countones(r_gptr ^ prev_g), 1);
      prev_g <= r_gptr;
    end
  end

  initial begin
    ae_thresh = 5'd2;
    repeat (2) @(negedge clk);
    chk("rst_rempty", rempty, 1); chk("rst_ralmost", ralmost_empty, 1);
    chk("rst_rcount", rcount, 0); chk("rst_r_gptr", r_gptr, 0);
    chk("rst_r_bptr", r_bptr, 0); chk("rst_uf", runderflow, 0);
    rrst_n = 1'b1;
    wr = 3;
    @(negedge clk); chk("lat1_rempty", rempty, 1); chk("lat1_rcount", rcount, 0);
    @(negedge clk); chk("lat2_rempty", rempty, 1); chk("lat2_rcount", rcount, 0);
    @(negedge clk); chk("lat3_rempty", rempty, 0); chk("lat3_rcount", rcount, 3);
    chk("lat3_ralmost", ralmost_empty, 0);
    rinc = 1'b1;
    @(negedge clk); chk("rd1_bptr", r_bptr, 1); chk("rd1_rcount", rcount, 2);
    @(negedge clk); chk("rd2_bptr", r_bptr, 2); chk("rd2_ralmost", ralmost_empty, 1);
    @(negedge clk); chk("rd3_bptr", r_bptr, 3); chk("rd3_rempty", rempty, 1);
    chk("rd3_rcount", rcount, 0);
    @(negedge clk); chk("rd4_hold_bptr", r_bptr, 3); chk("uf_set", runderflow, UF);
    clr_underflow = 1'b1;
    @(negedge clk); chk("uf_set_beats_clr", runderflow, UF);
    rinc = 1'b0;
    @(negedge clk); chk("uf_clr", runderflow, 0);
    clr_underflow = 1'b0;
    wr = 7;
    repeat (3) @(negedge clk);
    chk("ae_fill_rcount", rcount, 4); chk("ae_fill_ralmost", ralmost_empty, 0);
    rinc = 1'b1;
    @(negedge clk); chk("ae_rd1_rcount", rcount, 3);
    @(negedge clk); chk("ae_rd2_rcount", rcount, 2); chk("ae_rd2_ralmost", ralmost_empty, 1);
    ae_thresh = 5'd20;
    for (int i = 0; i < 40; i++) begin
      wr++;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    rinc = 1'b0;
    chk("wrap_rempty", rempty, 1); chk("wrap_rcount", rcount, 0);
    chk("wrap_r_bptr", r_bptr, 4'hf); chk("wrap_r_gptr", r_gptr, 5'b01000);
    chk("wrap_ralmost", ralmost_empty, 1);
    ae_thresh = 5'd0;
    wr = 52;
    repeat (3) @(negedge clk);
    chk("mid_rcount", rcount, 5); chk("mid_ralmost", ralmost_empty, 0);
    #2 rrst_n = 1'b0; wr = 0;
    #1;
    chk("mrst_rempty", rempty, 1); chk("mrst_ralmost", ralmost_empty, 1);
    chk("mrst_rcount", rcount, 0); chk("mrst_r_gptr", r_gptr, 0);
    chk("mrst_r_bptr", r_bptr, 0); chk("mrst_uf", runderflow, 0);
    @(negedge clk);
    rrst_n = 1'b1;
    wr = 2;
    repeat (4) @(negedge clk);
    chk("post_rcount", rcount, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rptr_empty_sync.md
Name: rptr_empty_sync

Overview:
- Parametrised read-side pointer and status block for the async FIFO. Successor to the fixed read-pointer/empty logic.
- Adds an internal write-pointer synchroniser of configurable depth, gray-to-binary conversion and a registered occupancy count.
- Adds a runtime-programmable almost-empty threshold and a sticky underflow flag.
- Sits in the read clock domain. Takes the raw write gray pointer from the write domain and produces the RAM read address and the read gray pointer for the write side.

Parameters:
- n, 4, address width; FIFO depth = 2^n; pointers are n+1 bits.
- SYNC_STAGES, 2, number of synchroniser flops on the incoming write gray pointer; legal values 2..4.

Ports:
- clk  input  1  read-domain clock.
- rrst_n  input  1  reset; asynchronous, active-low.
- rinc  input  1  read request; honoured only when rempty=0.
- w_gptr  input  n+1  write gray pointer from the write domain; asynchronous to clk.
- ae_thresh  input  n+1  almost-empty threshold, in entries; quasi-static.
- clr_underflow  input  1  clears runderflow.
- r_bptr  output  n  RAM read address; the lower n bits of the binary read pointer.
- r_gptr  output  n+1  registered gray read pointer, for synchronisation into the write domain.
- rcount  output  n+1  registered FIFO occupancy, 0..2^n.
- rempty  output  1  FIFO empty.
- ralmost_empty  output  1  occupancy <= ae_thresh.
- runderflow  output  1  sticky underflow flag.

Behaviour:
- Reset (rrst_n=0, asynchronous, active-low):
  - Binary pointer rbin, r_gptr and all synchroniser flops = 0.
  - rcount = 0.
  - rempty = 1.
  - ralmost_empty = 1.
  - runderflow = 0.
- Reset takes effect immediately, mid-operation included. The first clk edge after release behaves as a normal cycle.
- Read increment: rinc_ok = rinc & ~rempty.
  - rbin_next = rbin + rinc_ok, n+1 bits, wraps modulo 2^(n+1).
  - rbin and r_gptr update on every clk edge.
  - r_gptr = rbin_next ^ (rbin_next >> 1), registered.
  - r_bptr = rbin[n-1:0].
- Synchroniser: w_gptr passes through a chain of SYNC_STAGES flops, giving wq. No combinational logic sits between the stages.
  - wbin = gray2bin(wq), computed combinationally from the last stage only.
- Empty: rempty <= (bin2gray(rbin_next) == wq), registered.
  - Deassertion latency from a write-pointer change at the pins is SYNC_STAGES+1 clk edges.
  - Assertion on the last read takes effect on the same edge that consumes the entry.
- Count: rcount <= (wbin - rbin_next) mod 2^(n+1), registered, range 0..2^n.
  - 2^n (MSB set, lower bits 0) means full as seen from the read side.
- Almost-empty: ralmost_empty <= (count_next <= ae_thresh), unsigned compare, registered.
  - ae_thresh=0 makes ralmost_empty equivalent to rempty.
  - ae_thresh >= 2^n holds ralmost_empty=1 permanently.
- Pointer wrap: when rbin passes 2^(n+1)-1 -> 0, the gray code changes by one bit; count and empty stay correct across the wrap.
- Simultaneous read and write arrival: the count uses the post-read pointer and the current wq. Net change is 0 if one entry is read and one newly synchronised entry arrives.
- Underflow: rinc=1 while rempty=1 means the pointer holds and runderflow sets on the next edge.
  - The flag stays set until clr_underflow=1.
  - Set has priority over clear when both occur in the same cycle.
- No outputs are combinational from w_gptr.

Optional Feature:
- Macro: RPTR_UNDERFLOW_EN.
- Defined: sticky runderflow logic and clr_underflow as described above.
- Undefined: runderflow is tied to 0, clr_underflow is ignored, and no underflow flop is synthesised. All other behaviour is identical.

Test Plan:
All scenarios use n=4 and SYNC_STAGES=2.
- Reset check: assert rrst_n=0 mid-stream with rcount=5 -> immediately rempty=1, ralmost_empty=1, rcount=0, r_gptr=0, r_bptr=0, runderflow=0.
- Write arrival latency: drive w_gptr = gray(3) = 5'b00010 from the empty state -> rempty falls and rcount=3 on the 3rd clk edge, not earlier.
- Read to empty: from rcount=3, hold rinc=1 for 3 cycles -> r_bptr steps 0,1,2,3; rempty=1 after the 3rd edge; further rinc leaves r_bptr=3.
- Almost-empty threshold: ae_thresh=2 with the FIFO filled to 4 -> ralmost_empty=0. After 2 reads, rcount=2 and ralmost_empty=1.
- Wrap: run 40 write/read pairs -> rbin wraps 31->0; rempty and rcount stay consistent; r_gptr changes exactly 1 bit per increment.
- Underflow (macro defined): rinc=1 while rempty=1 -> runderflow=1 next edge. clr_underflow and rinc asserted together on an empty FIFO -> runderflow stays 1. clr_underflow alone -> runderflow=0. Macro undefined -> runderflow always 0.
